// File: rtl/math_equation_pkg.sv
// Shared widths and arithmetic helpers for the equation pipeline.
// The narrowing helper clamps to a signed range; the divide helper rounds toward zero.
package math_equation_pkg;

   // Working width for the final divide/narrow step (covers any legal FULL_W).
   localparam int CALC_W = 64;

   // Result of narrowing: clamped value plus a flag set when a clamp happened.
   typedef struct packed {
      logic              sat;
      logic [CALC_W-1:0] val;
   } narrow_t;

   function automatic int full_w(int width, int cw);
      return 2*width + cw + 3;
   endfunction

   function automatic int r0_w(int width, int cw);
      return width + cw + 1;
   endfunction

   function automatic int s0_w(int width);
      return width + 1;
   endfunction

   // Divide by 2**shift rounding toward zero: negative values get
   // (2**shift - 1) added first so the arithmetic shift does not round down.
   function automatic logic signed [CALC_W-1:0] div_pow2_trunc(
      input logic signed [CALC_W-1:0] value,
      input int                       shift
   );
      logic signed [CALC_W-1:0] adj;
      adj = '0;
      if (value[CALC_W-1])
         adj = (64'sd1 <<< shift) - 64'sd1;
      return (value + adj) >>> shift;
   endfunction

   // Clamp value into the signed out_w-bit range.
   function automatic narrow_t sat_narrow(
      input logic signed [CALC_W-1:0] value,
      input int                       out_w
   );
      narrow_t                  r;
      logic signed [CALC_W-1:0] hi;
      logic signed [CALC_W-1:0] lo;
      hi    = (64'sd1 <<< (out_w - 1)) - 64'sd1;
      lo    = -hi - 64'sd1;
      r.sat = 1'b0;
      r.val = value;
      if (value > hi) begin
         r.sat = 1'b1;
         r.val = hi;
      end else if (value < lo) begin
         r.sat = 1'b1;
         r.val = lo;
      end
      return r;
   endfunction

endpackage

// File: rtl/math_equation_pipe_stage_ctrl.sv
// One pipeline stage's valid flag and its advance term.
// A stage may load whenever downstream advances or it currently holds a bubble.
module pipe_stage_ctrl (
   input  logic clk,
   input  logic rst,
   input  logic up_valid,
   input  logic down_adv,
   output logic valid,
   output logic adv
);

   assign adv = down_adv || !valid;

   // Valid follows upstream on advance, holds while stalled, clears on reset.
   always_ff @(posedge clk) begin
      if (rst)
         valid <= 1'b0;
      else if (adv)
         valid <= up_valid;
   end

endmodule

// File: rtl/math_equation_pipe.sv
// 3-stage bubble-collapsing pipeline computing
//   q = ((BIAS + COEF_C*c)*(a - b) - (d <<< SHIFT_D)) / 2**DIV_SHIFT
// with valid/ready on both sides. Division rounds toward zero.
// Optional: MATH_EQ_PIPE_SAT_EN clamps q to the OUT_W signed range and adds sat_o;
// without it q is the low OUT_W bits of the result.
module math_equation_pipe
   import math_equation_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int CW        = 3,
   parameter int COEF_C    = 3,
   parameter int BIAS      = 1,
   parameter int SHIFT_D   = 2,
   parameter int DIV_SHIFT = 1,
   parameter int OUT_W     = full_w(WIDTH, CW)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    valid_i,
   output logic                    ready_o,
   input  logic signed [WIDTH-1:0] a,
   input  logic signed [WIDTH-1:0] b,
   input  logic signed [WIDTH-1:0] c,
   input  logic signed [WIDTH-1:0] d,
   output logic                    valid_o,
   input  logic                    ready_i,
   output logic signed [OUT_W-1:0] q
`ifdef MATH_EQ_PIPE_SAT_EN
   ,
   output logic                    sat_o
`endif
);

   localparam int FULL_W = full_w(WIDTH, CW);
   localparam int R0_W   = r0_w(WIDTH, CW);
   localparam int S0_W   = s0_w(WIDTH);

   localparam logic signed [CW-1:0] COEF_K = CW'(COEF_C);
   localparam logic signed [CW-1:0] BIAS_K = CW'(BIAS);

   logic v0, v1, v2;
   logic adv0, adv1, adv2;
   logic accept;

   logic signed [R0_W-1:0]   r0;
   logic signed [S0_W-1:0]   s0;
   logic signed [WIDTH-1:0]  d0;
   logic signed [FULL_W-1:0] p1;
   logic signed [FULL_W-1:0] e1;
   logic signed [FULL_W-1:0] t;
   logic signed [CALC_W-1:0] t_div;
   logic signed [OUT_W-1:0]  q_n;
   logic                     sat_n;

   // rst blocks acceptance in the reset cycle itself.
   assign ready_o = adv0 && !rst;
   assign accept  = valid_i && ready_o;
   assign valid_o = v2;

   pipe_stage_ctrl u_s0 (.clk(clk), .rst(rst), .up_valid(accept), .down_adv(adv1),    .valid(v0), .adv(adv0));
   pipe_stage_ctrl u_s1 (.clk(clk), .rst(rst), .up_valid(v0),     .down_adv(adv2),    .valid(v1), .adv(adv1));
   pipe_stage_ctrl u_s2 (.clk(clk), .rst(rst), .up_valid(v1),     .down_adv(ready_i), .valid(v2), .adv(adv2));

   // Stage 0: coefficient term, operand difference, and d captured on accept.
   always_ff @(posedge clk) begin
      if (adv0 && accept) begin
         r0 <= R0_W'(BIAS_K) + R0_W'(COEF_K) * R0_W'(c);
         s0 <= S0_W'(a) - S0_W'(b);
         d0 <= d;
      end
   end

   // Stage 1: product and shifted d, both at the exact result width.
   always_ff @(posedge clk) begin
      if (adv1 && v0) begin
         p1 <= FULL_W'(r0) * FULL_W'(s0);
         e1 <= FULL_W'(d0) <<< SHIFT_D;
      end
   end

   // Stage 2 combinational: difference, divide toward zero, narrow to OUT_W.
   always_comb begin
      t     = p1 - e1;
      t_div = div_pow2_trunc(CALC_W'(t), DIV_SHIFT);
`ifdef MATH_EQ_PIPE_SAT_EN
      begin
         narrow_t nr;
         nr    = sat_narrow(t_div, OUT_W);
         q_n   = OUT_W'(nr.val);
         sat_n = nr.sat;
      end
`else
      q_n   = OUT_W'(t_div);
      sat_n = 1'b0;
`endif
   end

   // Stage 2 register: result (and clamp flag) held stable while stalled.
   always_ff @(posedge clk) begin
      if (adv2 && v1) begin
         q <= q_n;
`ifdef MATH_EQ_PIPE_SAT_EN
         sat_o <= sat_n;
`endif
      end
   end

`ifndef MATH_EQ_PIPE_SAT_EN
   logic unused_sat;
   assign unused_sat = sat_n;
`endif

endmodule

// File: tb/tb_math_equation_pipe.sv
// Bench for math_equation_pipe: a full-width instance and an OUT_W=16 instance
// share stimulus; a queue-based model of the equation checks both every cycle.
module tb_math_equation_pipe;

   localparam int WIDTH = 8, CW = 3, COEF_C = 3, BIAS = 1, SHIFT_D = 2, DIV_SHIFT = 1;
   localparam int FULL_W = 2*WIDTH + CW + 3;

   logic clk = 1'b0, rst = 1'b1, valid_i = 1'b0, ready_i = 1'b0;
   logic signed [WIDTH-1:0] a = '0, b = '0, c = '0, d = '0;
   logic ready_o, valid_o, ready16, valid16;
   logic signed [FULL_W-1:0] q;
   logic signed [15:0] q16;
`ifdef MATH_EQ_PIPE_SAT_EN
   logic sat_o, sat16;
`endif

   always #5 clk = ~clk;

   math_equation_pipe #(.WIDTH(WIDTH), .CW(CW), .COEF_C(COEF_C), .BIAS(BIAS),
      .SHIFT_D(SHIFT_D), .DIV_SHIFT(DIV_SHIFT), .OUT_W(FULL_W)) dut (
      .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o),
      .a(a), .b(b), .c(c), .d(d), .valid_o(valid_o), .ready_i(ready_i), .q(q)
`ifdef MATH_EQ_PIPE_SAT_EN
      , .sat_o(sat_o)
`endif
   );

   math_equation_pipe #(.WIDTH(WIDTH), .CW(CW), .COEF_C(COEF_C), .BIAS(BIAS),
      .SHIFT_D(SHIFT_D), .DIV_SHIFT(DIV_SHIFT), .OUT_W(16)) dut16 (
      .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready16),
      .a(a), .b(b), .c(c), .d(d), .valid_o(valid16), .ready_i(ready_i), .q(q16)
`ifdef MATH_EQ_PIPE_SAT_EN
      , .sat_o(sat16)
`endif
   );

   typedef struct { longint full; int edge_n; } exp_t;
   exp_t mq[$];
   int   n_chk = 0, n_err = 0, cyc = 0, n_pop = 0;
   bit   chk_en = 1'b0;

   // Equation evaluated with plain integer arithmetic; '/' truncates toward zero.
   function automatic longint model_full(int ia, int ib, int ic, int id);
      longint t;
      t = longint'(BIAS + COEF_C*ic) * longint'(ia - ib) - longint'(id) * (longint'(1) << SHIFT_D);
      return t / (longint'(1) << DIV_SHIFT);
   endfunction

   function automatic bit out16(longint v);
      return (v > 32767) || (v < -32768);
   endfunction

   function automatic longint narrow16(longint v);
      longint w;
`ifdef MATH_EQ_PIPE_SAT_EN
      w = (v > 32767) ? 32767 : (v < -32768) ? -32768 : v;
`else
      w = v & 64'hFFFF;
      if (w >= 32768) w = w - 65536;
`endif
      return w;
   endfunction

   task automatic chk(input string name, input longint act, input longint exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Compare against the model, then apply the handshakes of the coming edge.
   always @(negedge clk) begin : cmp
      bit   ev, hs_in, hs_out;
      exp_t e;
      hs_in  = valid_i && ready_o;
      hs_out = valid_o && ready_i;
      ev     = (mq.size() > 0) && (cyc - mq[0].edge_n >= 2);
      if (chk_en) begin
         chk("ready_o", ready_o, !rst && (mq.size() < 3 || ready_i));
         chk("valid_o", valid_o, ev);
         chk("valid_o_16", valid16, ev);
         if (valid_o && ev) begin
            chk("q", q, mq[0].full);
            chk("q_16", q16, narrow16(mq[0].full));
`ifdef MATH_EQ_PIPE_SAT_EN
            chk("sat_o", sat_o, 0);
            chk("sat_16", sat16, out16(mq[0].full));
`endif
         end
      end
      if (rst) mq.delete();
      else begin
         if (hs_out && mq.size() > 0) begin
            void'(mq.pop_front());
            n_pop++;
         end
         if (hs_in) begin
            e.full   = model_full(a, b, c, d);
            e.edge_n = cyc + 1;
            mq.push_back(e);
         end
      end
      cyc++;
   end

   // One operand set into an idle pipe with ready_i=1; checks latency and q.
   task automatic single(input int ia, ib, ic, id, input longint exp, input longint exp16,
                         input string name);
      int lat;
      lat = 0;
      @(posedge clk); #1;
      valid_i = 1'b1; a = 8'(ia); b = 8'(ib); c = 8'(ic); d = 8'(id);
      @(posedge clk); #1;
      valid_i = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (valid_o) begin lat = k; break; end
      end
      chk({name, "_lat"}, lat, 3);
      chk({name, "_q"}, q, exp);
      chk({name, "_q16"}, q16, exp16);
   endtask

   int va[4] = '{3, -7, 100, -128};
   int vb[4] = '{-2, 50, -100, 127};
   int vc[4] = '{4, -1, 127, -128};
   int vd[4] = '{-5, 9, -128, 127};

   task automatic set_vec(input int i);
      a = 8'(va[i]); b = 8'(vb[i]); c = 8'(vc[i]); d = 8'(vd[i]);
   endtask

   initial begin : stim
      int acc, idx, pops0, cy;
      longint q_hold;
      bit have_hold, acc_now;

      repeat (3) @(posedge clk);
      #1 rst = 1'b0; ready_i = 1'b1; chk_en = 1'b1;

      // Hand-computed values pin the model itself.
      chk("model_basic", model_full(5, 2, 1, 1), 4);
      chk("model_trunc", model_full(0, 1, 0, 0), 0);
      chk("model_extreme", model_full(-128, 127, -128, 127), 48578);
`ifdef MATH_EQ_PIPE_SAT_EN
      chk("model_narrow16", narrow16(48578), 32767);
`else
      chk("model_narrow16", narrow16(48578), -16958);
`endif

      single(5, 2, 1, 1, 4, 4, "basic");
      single(0, 1, 0, 0, 0, 0, "trunc");
`ifdef MATH_EQ_PIPE_SAT_EN
      single(-128, 127, -128, 127, 48578, 32767, "extreme");
      chk("extreme_sat16", sat16, 1);
`else
      single(-128, 127, -128, 127, 48578, -16958, "extreme");
`endif

      // Output stalled: 3 accepted, 4th refused; q held; then all 4 drain in order.
      @(posedge clk); #1;
      ready_i = 1'b0; acc = 0; idx = 0; have_hold = 1'b0; q_hold = 0;
      set_vec(0); valid_i = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (valid_i && ready_o) begin acc++; idx++; end
         if (valid_o) begin
            if (have_hold) chk("stall_hold", q, q_hold);
            else begin q_hold = q; have_hold = 1'b1; end
         end
         if (k == 5) chk("stall_ready", ready_o, 0);
         @(posedge clk); #1;
         if (idx < 4) set_vec(idx);
      end
      chk("stall_acc", acc, 3);
      ready_i = 1'b1; pops0 = n_pop;
      for (int k = 0; k < 20 && !(acc == 4 && n_pop - pops0 == 4); k++) begin
         @(negedge clk);
         if (valid_i && ready_o) begin acc++; idx++; end
         @(posedge clk); #1;
         if (acc >= 4) valid_i = 1'b0;
         else set_vec(idx);
      end
      valid_i = 1'b0;
      chk("stall_pops", n_pop - pops0, 4);

      // Bubble collapse: one result stalled at the output, two more still enter.
      @(posedge clk); #1;
      ready_i = 1'b0; set_vec(1); valid_i = 1'b1;
      @(posedge clk); #1;
      valid_i = 1'b0;
      repeat (2) @(posedge clk);
      #1 acc = 0; set_vec(2); valid_i = 1'b1;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         chk("bubble_ready", ready_o, 1);
         if (valid_i && ready_o) acc++;
         @(posedge clk); #1;
         set_vec(3);
      end
      valid_i = 1'b0;
      chk("bubble_acc", acc, 2);
      ready_i = 1'b1;
      repeat (6) @(posedge clk);

      // Random valid/ready traffic until 1000 results have left.
      #1 pops0 = n_pop; acc_now = 1'b0;
      for (cy = 0; cy < 8000 && n_pop - pops0 < 1000; cy++) begin
         @(negedge clk);
         acc_now = valid_i && ready_o;
         @(posedge clk); #1;
         if (!valid_i || acc_now) begin
            valid_i = ($urandom % 4) != 0;
            a = 8'($urandom); b = 8'($urandom); c = 8'($urandom); d = 8'($urandom);
         end
         ready_i = ($urandom % 3) != 0;
      end
      chk("rand_results", (n_pop - pops0 >= 1000) ? 1 : 0, 1);
      valid_i = 1'b0; ready_i = 1'b1;
      repeat (6) @(posedge clk);

      // Reset with 3 sets in flight discards them; next set is correct.
      #1 ready_i = 1'b0;
      for (int k = 0; k < 3; k++) begin
         set_vec(k); valid_i = 1'b1;
         @(posedge clk); #1;
      end
      valid_i = 1'b0; rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rst_valid", valid_o, 0);
      chk("rst_ready", ready_o, 1);
      ready_i = 1'b1;
      repeat (4) @(posedge clk);
      single(5, 2, 1, 1, 4, 4, "post_rst");
      repeat (4) @(posedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
      $finish;
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
      $fatal(1);
   end

endmodule

// File: doc/math_equation_pipe.md
Name: math_equation_pipe

Overview:
- Parametrised successor to the fixed 3-stage equation pipeline.
- Evaluates q = ((BIAS + COEF_C*c)*(a - b) - (d <<< SHIFT_D)) / 2**DIV_SHIFT on signed operands, with a full valid/ready handshake on both sides.
- Uses a bubble-collapsing 3-stage pipeline and a parametrised output width.
- Sits between an operand producer and a result consumer that may stall.

Parameters:
- WIDTH, 8: width of signed operands a, b, c, d.
- CW, 3: signed width holding COEF_C and BIAS.
- COEF_C, 3: signed multiplier applied to c; must fit in CW bits.
- BIAS, 1: signed offset added to COEF_C*c; must fit in CW bits.
- SHIFT_D, 2: left-shift applied to d (0..7).
- DIV_SHIFT, 1: divisor exponent (0..7); division truncates toward zero.
- FULL_W, 2*WIDTH+CW+3: derived localparam, the exact result width.
- OUT_W, FULL_W: output width; must satisfy 2 <= OUT_W <= FULL_W.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- valid_i  in  1  operand set valid.
- ready_o  out  1  block can accept an operand set this cycle.
- a, b, c, d  in  WIDTH each  signed operands, sampled when valid_i && ready_o.
- valid_o  out  1  result valid.
- ready_i  in  1  consumer accepts the result.
- q  out  OUT_W  signed result.

Behaviour:
- Reset: one clock, synchronous, active-high. On rst the stage valids v0, v1, v2 clear at the next edge and valid_o = 0. Data registers are not reset; q is don't-care while valid_o = 0.
- Stage 0 (on accept):
  - r0 = BIAS + COEF_C*c, WIDTH+CW+1 bits.
  - s0 = a - b, WIDTH+1 bits.
  - d0 = d.
- Stage 1:
  - p1 = r0*s0, sign-extended to FULL_W.
  - e1 = d0 <<< SHIFT_D, sign-extended to FULL_W.
- Stage 2:
  - t = p1 - e1, computed at FULL_W, never overflows.
  - t is divided by 2**DIV_SHIFT with truncation toward zero; a plain arithmetic shift is not acceptable for negative t.
  - The result is then narrowed to OUT_W (see Optional Feature).
- Advance rules:
  - adv2 = ready_i || !v2.
  - adv1 = adv2 || !v1.
  - adv0 = adv1 || !v0.
  - ready_o = adv0, combinational from ready_i; no registered skid buffer.
  - A stage loads when its advance is high. Its valid takes the upstream valid (valid_i && ready_o for stage 0). Data registers load only when the upstream valid is 1.
  - A stalled stage holds data and valid unchanged.
- Latency: 3 cycles from accept to valid_o when unstalled. Throughput: 1 result per cycle. Capacity: 3 in-flight sets.
- Bubbles collapse: a stalled output does not block upstream stages that hold bubbles.
- Simultaneous accept and output pop when full: both occur and the occupancy stays at 3.
- valid_o and q hold stable while valid_o && !ready_i (AXI-style); results are never dropped or duplicated, and order is preserved.
- rst asserted mid-stream: all in-flight results are discarded. ready_o = 1 from the cycle after reset (rst forces ready_o = 0 combinationally).

Optional Feature:
- Macro: MATH_EQ_PIPE_SAT_EN.
- Defined: if the divided result lies outside the OUT_W signed range, q clamps to +(2**(OUT_W-1)-1) or -(2**(OUT_W-1)).
  - Adds output sat_o (1 bit, qualified by valid_o), which is 1 when a clamp occurred.
- Undefined: q is the low OUT_W bits (two's-complement wrap) and sat_o does not exist.
- With OUT_W == FULL_W, both builds give identical q.

Decomposition:
- Package math_equation_pkg holds:
  - width functions: full_w(WIDTH, CW), r0_w, s0_w;
  - function sat_narrow(value, out_w);
  - function div_pow2_trunc(value, shift).
- Single sub-module pipe_stage_ctrl: one valid register with its advance logic, instantiated 3 times.
- Datapath stays in the top level.

Test Plan:
- Default parameters, a=5 b=2 c=1 d=1, ready_i=1: valid_o rises 3 cycles after accept, q = 4.
- a=0 b=1 c=0 d=0: t = -1, q = 0 (truncation toward zero, not -1).
- a=-128 b=127 c=-128 d=127:
  - full width: q = 48578;
  - OUT_W=16 with MATH_EQ_PIPE_SAT_EN: q = 32767, sat_o = 1;
  - OUT_W=16 without the macro: q = -16958.
- ready_i=0 with 4 back-to-back valid_i:
  - 3 sets accepted, ready_o = 0 on the 4th;
  - after ready_i=1, 4 results emerge in order, with no loss or duplicate;
  - q holds stable throughout the stall.
- Bubble collapse:
  - v2=1 and stalled, v0=v1=0: ready_o stays 1 and two further sets are accepted;
  - randomized ready_i against a reference model: 1000 results match.
- rst pulsed while 3 sets are in flight: valid_o = 0 the next cycle and no stale result appears afterward; the first post-reset set yields a correct q at latency 3.
